// File: rtl/dispatch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_buffer_pkg
// Description : Shared types and constants for the fetch -> dispatch queue.
//               Holds the superscalar width, the fetch/dispatch payload type,
//               the default queue depth and the lane-group packet types.
// Revision    : 1.0 - initial release
// ============================================================================
package dispatch_buffer_pkg;

   // Superscalar width shared by fetch and dispatch.
   localparam int SUPERSCALAR_WAYS      = 3;
   localparam int SUPERSCALAR_WAYS_BITS = $clog2(SUPERSCALAR_WAYS + 1);

   // Payload carried for one instruction from fetch to dispatch (96 bits).
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] npc;
   } FETCH_DISPATCH_PACKET;

   // Default storage depth of the dispatch buffer.
   localparam int DISPATCH_BUF_DEPTH = 8;

   // One lane group entering the buffer (holes allowed in valid).
   typedef struct packed {
      logic [SUPERSCALAR_WAYS-1:0]                       valid;
      FETCH_DISPATCH_PACKET [SUPERSCALAR_WAYS-1:0]       data;
   } DISPATCH_BUF_IN_PACKET;

   // Oldest entries presented to dispatch (valid is thermometer-coded).
   typedef struct packed {
      logic [SUPERSCALAR_WAYS-1:0]                       valid;
      FETCH_DISPATCH_PACKET [SUPERSCALAR_WAYS-1:0]       data;
   } DISPATCH_BUF_OUT_PACKET;

endpackage
`default_nettype wire

// File: rtl/dispatch_buffer_lane_compactor.sv
`default_nettype none
// ============================================================================
// Module      : lane_compactor
// Description : Combinational prefix popcount over the fetch valid lanes.
//               offset[i] is the number of valid lanes below lane i, i.e. the
//               compacted write slot of lane i relative to the tail; n_in is
//               the total number of valid lanes.
// Ports       : in_valid [WAYS]          per-lane valid from fetch
//               offset   [WAYS][WAY_W]   compacted slot offset per lane
//               n_in     [WAY_W]         popcount of in_valid
// Revision    : 1.0 - initial release
// ============================================================================
module lane_compactor #(
   parameter int WAYS  = 3,
   parameter int WAY_W = $clog2(WAYS + 1)
) (
   input  logic [WAYS-1:0]             in_valid,
   output logic [WAYS-1:0][WAY_W-1:0]  offset,
   output logic [WAY_W-1:0]            n_in
);

   logic [WAY_W-1:0] run;

   always_comb begin
      run    = '0;
      offset = '0;
      for (int i = 0; i < WAYS; i++) begin
         offset[i] = run;
         run       = run + WAY_W'(in_valid[i]);
      end
      n_in = run;
   end

endmodule
`default_nettype wire

// File: rtl/dispatch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_buffer
// Description : In-order instruction queue between fetch and dispatch/rename.
//               Accepts up to WAYS (sparse, compacted) instructions per cycle
//               and presents the oldest WAYS entries; dispatch retires a
//               variable-length head group each cycle.
// Ports       : clock       rising-edge clock
//               reset       asynchronous, active-low
//               flush_en    empties the buffer (push/pop ignored that cycle)
//               in_valid    per-lane valid from fetch, holes allowed
//               in_data     fetch payload, lane 0 oldest
//               in_ready    whole group accepted this cycle
//               free_slots  DEPTH - count (from registered count)
//               out_valid   lane i valid iff count > i
//               out_data    head+i entry on lane i, zero when invalid
//               out_accept  number of head entries consumed (0..WAYS)
//               count       current occupancy
//               empty/full  count == 0 / count == DEPTH
//               accept_err  sticky over-accept indicator
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_buffer
   import dispatch_buffer_pkg::*;
#(
   parameter int WAYS   = SUPERSCALAR_WAYS,
   parameter int DEPTH  = DISPATCH_BUF_DEPTH,
   parameter int DATA_W = $bits(FETCH_DISPATCH_PACKET),
   parameter int CNT_W  = $clog2(DEPTH + 1),
   parameter int WAY_W  = $clog2(WAYS + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush_en,
   input  logic [WAYS-1:0]          in_valid,
   input  logic [WAYS*DATA_W-1:0]   in_data,
   output logic                     in_ready,
   output logic [CNT_W-1:0]         free_slots,
   output logic [WAYS-1:0]          out_valid,
   output logic [WAYS*DATA_W-1:0]   out_data,
   input  logic [WAY_W-1:0]         out_accept,
   output logic [CNT_W-1:0]         count,
   output logic                     empty,
   output logic                     full,
   output logic                     accept_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AW    = CNT_W + 1;   // arithmetic width, never overflows
   localparam int SW    = AW + 1;      // pointer-sum width

   if (DEPTH < WAYS || WAYS < 1) begin : g_bad_params
      $fatal(1, "dispatch_buffer: requires WAYS >= 1 and DEPTH >= WAYS");
   end

   // Pointer advance with wrap by compare, so DEPTH need not be a power of 2.
   // base < DEPTH and off <= DEPTH, so a single subtraction is enough.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input logic [AW-1:0]    off);
      logic [SW-1:0] sum;
      sum = SW'(base) + SW'(off);
      if (sum >= SW'(DEPTH)) sum = sum - SW'(DEPTH);
      return IDX_W'(sum);
   endfunction

   logic [DATA_W-1:0]            mem [DEPTH];
   logic [IDX_W-1:0]             head;
   logic [IDX_W-1:0]             tail;

   logic [WAYS-1:0][WAY_W-1:0]   offset;
   logic [WAY_W-1:0]             n_in;
   logic [AW-1:0]                count_ext;
   logic [AW-1:0]                accept_ext;
   logic [AW-1:0]                pop_n;
   logic [AW-1:0]                push_n;
   logic                         over_accept;
   logic                         push_en;

   lane_compactor #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_lane_compactor (
      .in_valid (in_valid),
      .offset   (offset),
      .n_in     (n_in)
   );

   // Admission looks only at the registered count; same-cycle pops are not
   // credited so there is no combinational path from out_accept to in_ready.
   assign free_slots  = CNT_W'(DEPTH) - count;
   assign in_ready    = AW'(n_in) <= AW'(free_slots);
   assign push_en     = in_ready && !flush_en;

   assign count_ext   = AW'(count);
   assign accept_ext  = AW'(out_accept);
   assign over_accept = accept_ext > count_ext;
   assign pop_n       = over_accept ? count_ext : accept_ext;
   assign push_n      = in_ready ? AW'(n_in) : '0;

   assign empty       = (count == '0);
   assign full        = (count == CNT_W'(DEPTH));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         accept_err <= 1'b0;
      end else if (flush_en) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
      end else begin
         head       <= wrap_add(head, pop_n);
         tail       <= wrap_add(tail, push_n);
         count      <= CNT_W'(count_ext - pop_n + push_n);
         if (over_accept) accept_err <= 1'b1;
      end
   end

   // Storage carries no reset; entries are only exposed once counted valid.
   always_ff @(posedge clock) begin
      if (push_en) begin
         for (int i = 0; i < WAYS; i++) begin
            if (in_valid[i]) begin
               mem[wrap_add(tail, AW'(offset[i]))] <= in_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   for (genvar i = 0; i < WAYS; i++) begin : g_out_lane
      assign out_valid[i] = count_ext > AW'(i);
      assign out_data[i*DATA_W +: DATA_W] =
         out_valid[i] ? mem[wrap_add(head, AW'(i))] : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_dispatch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_buffer
// Description : Directed self-checking bench for dispatch_buffer
//               (WAYS=3, DEPTH=8, DATA_W=96).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_buffer;

   localparam int WAYS   = 3;
   localparam int DEPTH  = 8;
   localparam int DATA_W = 96;
   localparam int CNT_W  = 4;
   localparam int WAY_W  = 2;

   logic                    clock;
   logic                    reset;
   logic                    flush_en;
   logic [WAYS-1:0]         in_valid;
   logic [WAYS*DATA_W-1:0]  in_data;
   logic                    in_ready;
   logic [CNT_W-1:0]        free_slots;
   logic [WAYS-1:0]         out_valid;
   logic [WAYS*DATA_W-1:0]  out_data;
   logic [WAY_W-1:0]        out_accept;
   logic [CNT_W-1:0]        count;
   logic                    empty;
   logic                    full;
   logic                    accept_err;

   int errors = 0;
   int checks = 0;

   dispatch_buffer #(
      .WAYS   (WAYS),
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .WAY_W  (WAY_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .flush_en   (flush_en),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .free_slots (free_slots),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_accept (out_accept),
      .count      (count),
      .empty      (empty),
      .full       (full),
      .accept_err (accept_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] lane(input int i);
      return out_data[i*DATA_W +: DATA_W];
   endfunction

   task automatic set_in(input logic [2:0] v, input logic [95:0] d0, input logic [95:0] d1,
                         input logic [95:0] d2, input logic [1:0] acc, input logic fl);
      in_valid   = v;
      in_data    = {d2, d1, d0};
      out_accept = acc;
      flush_en   = fl;
   endtask

   // Advance one edge, then clear inputs and let outputs settle.
   task automatic tick();
      @(posedge clock);
      #1;
      set_in(3'b000, 96'h0, 96'h0, 96'h0, 2'd0, 1'b0);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      set_in(3'b000, 96'h0, 96'h0, 96'h0, 2'd0, 1'b0);
      #3;
      // Reset state
      check("rst_count",     96'(count),      96'd0);
      check("rst_out_valid", 96'(out_valid),  96'b000);
      check("rst_empty",     96'(empty),      96'd1);
      check("rst_full",      96'(full),       96'd0);
      check("rst_free",      96'(free_slots), 96'd8);
      check("rst_in_ready",  96'(in_ready),   96'd1);
      check("rst_err",       96'(accept_err), 96'd0);
      check("rst_lane0",     lane(0),         96'h0);
      #4 reset = 1'b1;

      // Sparse push: lanes 0 and 2, lane 1 is a hole
      set_in(3'b101, 96'hA, 96'hBAD, 96'hC, 2'd0, 1'b0);
      #1 check("sparse_in_ready", 96'(in_ready), 96'd1);
      tick();
      check("sparse_out_valid", 96'(out_valid),  96'b011);
      check("sparse_lane0",     lane(0),         96'hA);
      check("sparse_lane1",     lane(1),         96'hC);
      check("sparse_lane2",     lane(2),         96'h0);
      check("sparse_count",     96'(count),      96'd2);
      check("sparse_free",      96'(free_slots), 96'd6);

      // Fill to 5, then asynchronous reset between edges
      set_in(3'b111, 96'hD, 96'hE, 96'hF, 2'd0, 1'b0);
      tick();
      check("fill5_count", 96'(count), 96'd5);
      check("fill5_lane2", lane(2),    96'hD);
      #2 reset = 1'b0;
      #1;
      check("arst_count",     96'(count),      96'd0);
      check("arst_out_valid", 96'(out_valid),  96'b000);
      check("arst_free",      96'(free_slots), 96'd8);
      check("arst_err",       96'(accept_err), 96'd0);
      check("arst_empty",     96'(empty),      96'd1);
      #1 reset = 1'b1;

      // Backpressure: count 6, group of 3 rejected, group of 2 accepted
      set_in(3'b111, 96'h10, 96'h11, 96'h12, 2'd0, 1'b0);
      tick();
      set_in(3'b111, 96'h13, 96'h14, 96'h15, 2'd0, 1'b0);
      tick();
      check("bp_count6", 96'(count),      96'd6);
      check("bp_free2",  96'(free_slots), 96'd2);
      set_in(3'b111, 96'h20, 96'h21, 96'h22, 2'd0, 1'b0);
      #1 check("bp_reject_ready", 96'(in_ready), 96'd0);
      tick();
      check("bp_reject_count", 96'(count), 96'd6);
      set_in(3'b011, 96'h16, 96'h17, 96'hBAD, 2'd0, 1'b0);
      #1 check("bp_accept_ready", 96'(in_ready), 96'd1);
      tick();
      check("bp_full_count", 96'(count),      96'd8);
      check("bp_full",       96'(full),       96'd1);
      check("bp_free0",      96'(free_slots), 96'd0);
      check("bp_empty_grp",  96'(in_ready),   96'd1);
      check("bp_lane0",      lane(0),         96'h10);
      check("bp_lane2",      lane(2),         96'h12);

      // Drain to head=6 with count=3 (one entry wraps to index 0)
      set_in(3'b000, 96'h0, 96'h0, 96'h0, 2'd3, 1'b0);
      tick();
      check("pop3_count", 96'(count), 96'd5);
      check("pop3_lane0", lane(0),    96'h13);
      set_in(3'b001, 96'h18, 96'h0, 96'h0, 2'd3, 1'b0);
      #1 check("pp_ready", 96'(in_ready), 96'd1);
      tick();
      check("pp_count",     96'(count),     96'd3);
      check("pp_out_valid", 96'(out_valid), 96'b111);
      check("pp_lane0",     lane(0),        96'h16);
      check("pp_lane1",     lane(1),        96'h17);
      check("pp_lane2",     lane(2),        96'h18);

      // Push 3 and pop 2 at head=6: head -> 0, tail -> 4, count 4
      set_in(3'b111, 96'h19, 96'h1A, 96'h1B, 2'd2, 1'b0);
      #1 check("wrap_ready", 96'(in_ready), 96'd1);
      tick();
      check("wrap_count", 96'(count),      96'd4);
      check("wrap_lane0", lane(0),         96'h18);
      check("wrap_lane1", lane(1),         96'h19);
      check("wrap_lane2", lane(2),         96'h1A);
      check("wrap_err",   96'(accept_err), 96'd0);

      // Flush overrides push and pop
      set_in(3'b111, 96'h2A, 96'h2B, 96'h2C, 2'd3, 1'b1);
      tick();
      check("flush_count",     96'(count),      96'd0);
      check("flush_empty",     96'(empty),      96'd1);
      check("flush_out_valid", 96'(out_valid),  96'b000);
      check("flush_err",       96'(accept_err), 96'd0);
      check("flush_free",      96'(free_slots), 96'd8);

      // Single entry after flush lands at index 0
      set_in(3'b001, 96'h30, 96'h0, 96'h0, 2'd0, 1'b0);
      tick();
      check("post_flush_count", 96'(count),     96'd1);
      check("post_flush_lane0", lane(0),        96'h30);
      check("post_flush_valid", 96'(out_valid), 96'b001);

      // Over-accept: clamp and set sticky error
      set_in(3'b000, 96'h0, 96'h0, 96'h0, 2'd3, 1'b0);
      tick();
      check("over_count", 96'(count),      96'd0);
      check("over_err",   96'(accept_err), 96'd1);

      // Normal traffic afterwards keeps the error set
      set_in(3'b110, 96'hBAD, 96'h41, 96'h42, 2'd0, 1'b0);
      tick();
      check("sticky_count", 96'(count),      96'd2);
      check("sticky_lane0", lane(0),         96'h41);
      check("sticky_lane1", lane(1),         96'h42);
      check("sticky_err1",  96'(accept_err), 96'd1);
      set_in(3'b000, 96'h0, 96'h0, 96'h0, 2'd2, 1'b0);
      tick();
      check("sticky_drain", 96'(count),      96'd0);
      check("sticky_err2",  96'(accept_err), 96'd1);

      // Only reset clears the error
      #2 reset = 1'b0;
      #1 check("err_cleared", 96'(accept_err), 96'd0);
      #1 reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
